// File: rtl/apb_slave_regfile.sv
// APB completer with NUM_REGS x 32-bit R/W registers and registered PREADY/PRDATA/PSLVERR.
// Optional macro APB_SLV_WAIT_EN adds WAIT_CFG at offset NUM_REGS*4 for 0..15 wait states.
module apb_slave_regfile #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 8,
    parameter int DEF_WAIT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr
);
    localparam int IDX_W = $clog2(NUM_REGS);
    localparam logic [ADDR_W-1:0] MAP_END = ADDR_W'(NUM_REGS * 4);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              in_range_q, in_range_d;
    logic              is_wcfg_q, is_wcfg_d;
    logic              pwrite_q, pwrite_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              pready_q, pready_d;
    logic              pslverr_q, pslverr_d;
    logic [DATA_W-1:0] prdata_q, prdata_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    logic              hit_reg, hit_wcfg, hit_any;
    logic [3:0]        wait_w;
    logic [IDX_W-1:0]  idx_in;
    logic [DATA_W-1:0] rd_setup, rd_held;
    logic              unused_ok;

    assign idx_in  = paddr[2 +: IDX_W];
    assign hit_reg = paddr < MAP_END;
    assign hit_any = hit_reg | hit_wcfg;

`ifdef APB_SLV_WAIT_EN
    logic [3:0] wait_cfg_q, wait_cfg_d;

    assign unused_ok = ^paddr[1:0];
    assign hit_wcfg  = paddr[ADDR_W-1:2] == MAP_END[ADDR_W-1:2];
    assign wait_w    = wait_cfg_q;
    assign rd_setup  = hit_wcfg ? DATA_W'(wait_cfg_q) : regs_q[idx_in];
    assign rd_held   = is_wcfg_q ? DATA_W'(wait_cfg_q) : regs_q[idx_q];

    always_comb begin
        wait_cfg_d = wait_cfg_q;
        if (state_q == ACCESS && psel && penable && pready_q && pwrite_q && is_wcfg_q) begin
            wait_cfg_d = pwdata[3:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cfg_q <= 4'(DEF_WAIT);
        end else begin
            wait_cfg_q <= wait_cfg_d;
        end
    end
`else
    assign unused_ok = ^{paddr[1:0], is_wcfg_q, 4'(DEF_WAIT)};
    assign hit_wcfg  = 1'b0;
    assign wait_w    = 4'd0;
    assign rd_setup  = regs_q[idx_in];
    assign rd_held   = regs_q[idx_q];
`endif

    // With zero wait states the response is launched on the setup edge itself,
    // so the first access cycle already sees pready.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        in_range_d = in_range_q;
        is_wcfg_d  = is_wcfg_q;
        pwrite_d   = pwrite_q;
        cnt_d      = cnt_q;
        pready_d   = pready_q;
        pslverr_d  = pslverr_q;
        prdata_d   = prdata_q;
        regs_d     = regs_q;

        case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    state_d    = ACCESS;
                    idx_d      = idx_in;
                    in_range_d = hit_any;
                    is_wcfg_d  = hit_wcfg;
                    pwrite_d   = pwrite;
                    cnt_d      = wait_w;
                    if (wait_w == 4'd0) begin
                        pready_d  = 1'b1;
                        pslverr_d = !hit_any;
                        prdata_d  = (!pwrite && hit_any) ? rd_setup : '0;
                    end
                end
            end
            ACCESS: begin
                if (!psel) begin
                    state_d   = IDLE;
                    cnt_d     = 4'd0;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    prdata_d  = '0;
                end else if (pready_q) begin
                    if (penable) begin
                        if (pwrite_q && in_range_q && !is_wcfg_q) begin
                            regs_d[idx_q] = pwdata;
                        end
                        state_d   = IDLE;
                        pready_d  = 1'b0;
                        pslverr_d = 1'b0;
                        prdata_d  = '0;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        cnt_d     = 4'd0;
                        pready_d  = 1'b1;
                        pslverr_d = !in_range_q;
                        prdata_d  = (!pwrite_q && in_range_q) ? rd_held : '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            in_range_q <= 1'b0;
            is_wcfg_q  <= 1'b0;
            pwrite_q   <= 1'b0;
            cnt_q      <= 4'd0;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            prdata_q   <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            in_range_q <= in_range_d;
            is_wcfg_q  <= is_wcfg_d;
            pwrite_q   <= pwrite_d;
            cnt_q      <= cnt_d;
            pready_q   <= pready_d;
            pslverr_q  <= pslverr_d;
            prdata_q   <= prdata_d;
            regs_q     <= regs_d;
        end
    end

    assign pready  = pready_q;
    assign pslverr = pslverr_q;
    assign prdata  = prdata_q;
endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile: vector table plus hand-written corner sequences.
// Covers the default build; the APB_SLV_WAIT_EN sequence is compiled in only with the macro.
module tb_apb_slave_regfile;
    logic        clk;
    logic        rst_n;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [15];

`ifdef APB_SLV_WAIT_EN
    localparam logic WCFG_ERR = 1'b0;
`else
    localparam logic WCFG_ERR = 1'b1;
`endif

    apb_slave_regfile dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the completing edge with the bus idle.
    task automatic applyStimulus(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                                 output logic [31:0] rdata, output logic err, output int lat);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wdata;
        @(negedge clk);
        penable = 1'b1;
        lat = 1;
        while (!pready && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        rdata = prdata;
        err   = pslverr;
        checks++;
        if (!pready) begin
            errors++;
            $display("[TB] FAIL pready_timeout: got 0 expected 1 (addr %h)", addr);
        end
        @(negedge clk);
        psel    = 1'b0;
        penable = 1'b0;
        checkOutput("pready_single_pulse", 32'(pready), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;

        vecs[0]  = '{1'b1, 12'h004, 32'hA5A5_0001, 32'h0,          1'b0};
        vecs[1]  = '{1'b0, 12'h004, 32'h0,         32'hA5A5_0001, 1'b0};
        vecs[2]  = '{1'b0, 12'h100, 32'h0,         32'h0,          1'b1};
        vecs[3]  = '{1'b1, 12'h100, 32'hDEAD_BEEF, 32'h0,          1'b1};
        vecs[4]  = '{1'b0, 12'h000, 32'h0,         32'h0,          1'b0};
        vecs[5]  = '{1'b0, 12'h008, 32'h0,         32'h0,          1'b0};
        vecs[6]  = '{1'b0, 12'h01C, 32'h0,         32'h0,          1'b0};
        vecs[7]  = '{1'b1, 12'h01C, 32'h0BAD_F00D, 32'h0,          1'b0};
        vecs[8]  = '{1'b0, 12'h01C, 32'h0,         32'h0BAD_F00D, 1'b0};
        vecs[9]  = '{1'b0, 12'h020, 32'h0,         32'h0,          WCFG_ERR};
        vecs[10] = '{1'b1, 12'h006, 32'h1111_2222, 32'h0,          1'b0};
        vecs[11] = '{1'b0, 12'h004, 32'h0,         32'h1111_2222, 1'b0};
        vecs[12] = '{1'b0, 12'h018, 32'h0,         32'h0,          1'b0};
        vecs[13] = '{1'b1, 12'h7FC, 32'h1234_5678, 32'h0,          1'b1};
        vecs[14] = '{1'b0, 12'h01C, 32'h0,         32'h0BAD_F00D, 1'b0};

        rst_n   = 1'b1;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        #3 rst_n = 1'b0;
        #1;
        checkOutput("reset_pready",  32'(pready),  32'd0);
        checkOutput("reset_pslverr", 32'(pslverr), 32'd0);
        checkOutput("reset_prdata",  prdata,       32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er, lat);
            checkOutput($sformatf("vec%0d_prdata", i),  rd,         vecs[i].exp_rdata);
            checkOutput($sformatf("vec%0d_pslverr", i), 32'(er),    32'(vecs[i].exp_err));
            checkOutput($sformatf("vec%0d_latency", i), 32'(lat),   32'd1);
            if (i % 2 == 1) @(negedge clk);
        end

        // Back-to-back write then read of the same word with no idle cycle.
        applyStimulus(1'b1, 12'h008, 32'h0000_1234, rd, er, lat);
        applyStimulus(1'b0, 12'h008, 32'h0, rd, er, lat);
        checkOutput("b2b_prdata",  rd,         32'h0000_1234);
        checkOutput("b2b_latency", 32'(lat),   32'd1);
        @(negedge clk);

        // psel withdrawn during the access phase must not commit the write.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h00C; pwdata = 32'h0000_FFFF;
        @(negedge clk);
        psel = 1'b0; penable = 1'b1;
        @(negedge clk);
        checkOutput("drop_pready",  32'(pready),  32'd0);
        checkOutput("drop_pslverr", 32'(pslverr), 32'd0);
        penable = 1'b0;
        @(negedge clk);
        applyStimulus(1'b0, 12'h00C, 32'h0, rd, er, lat);
        checkOutput("drop_reg_unchanged", rd, 32'h0);
        @(negedge clk);

        // penable without a setup phase is not a transfer.
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 12'h014; pwdata = 32'h0000_0077;
        @(negedge clk);
        checkOutput("nosetup_pready_c1", 32'(pready), 32'd0);
        @(negedge clk);
        checkOutput("nosetup_pready_c2", 32'(pready), 32'd0);
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        applyStimulus(1'b0, 12'h014, 32'h0, rd, er, lat);
        checkOutput("nosetup_reg_unchanged", rd, 32'h0);
        @(negedge clk);

`ifdef APB_SLV_WAIT_EN
        applyStimulus(1'b1, 12'h020, 32'h0000_0003, rd, er, lat);
        checkOutput("wcfg_wr_pslverr", 32'(er), 32'd0);
        @(negedge clk);
        applyStimulus(1'b0, 12'h000, 32'h0, rd, er, lat);
        checkOutput("wait3_latency", 32'(lat), 32'd4);
        applyStimulus(1'b0, 12'h020, 32'h0, rd, er, lat);
        checkOutput("wcfg_rd_value", rd, 32'h3);
        applyStimulus(1'b1, 12'h020, 32'hFFFF_FFF0, rd, er, lat);
        applyStimulus(1'b0, 12'h020, 32'h0, rd, er, lat);
        checkOutput("wcfg_upper_zero", rd, 32'h0);
        checkOutput("wait0_latency", 32'(lat), 32'd1);
        @(negedge clk);
`endif

        applyStimulus(1'b1, 12'h010, 32'h0000_55AA, rd, er, lat);
        @(negedge clk);

        // Reset asserted while a read is in its access phase clears outputs immediately.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h010;
        @(negedge clk);
        penable = 1'b1;
        #1;
        checkOutput("midrst_pre_pready", 32'(pready), 32'd1);
        checkOutput("midrst_pre_prdata", prdata,      32'h0000_55AA);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midrst_pready",  32'(pready),  32'd0);
        checkOutput("midrst_pslverr", 32'(pslverr), 32'd0);
        checkOutput("midrst_prdata",  prdata,       32'd0);
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(1'b0, 12'h010, 32'h0, rd, er, lat);
        checkOutput("postrst_reg010", rd, 32'h0);
        applyStimulus(1'b0, 12'h004, 32'h0, rd, er, lat);
        checkOutput("postrst_reg004", rd, 32'h0);
        applyStimulus(1'b1, 12'h010, 32'h0000_CAFE, rd, er, lat);
        applyStimulus(1'b0, 12'h010, 32'h0, rd, er, lat);
        checkOutput("postrst_rw",      rd,         32'h0000_CAFE);
        checkOutput("postrst_latency", 32'(lat),   32'd1);
        checkOutput("postrst_pslverr", 32'(er),    32'd0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
